// File: rtl/prim_unpacker.sv
// rtl/prim_unpacker.sv - masked wide-to-narrow stream unpacker; PRIM_UNPACKER_OUT_REG_EN adds an output register
module prim_unpacker #(
  parameter int unsigned InW          = 32,
  parameter int unsigned OutW         = 8,
  parameter bit          HintByteData = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic [InW-1:0]  data_i,
  input  logic [InW-1:0]  mask_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [OutW-1:0] data_o,
  output logic [OutW-1:0] mask_o,
  input  logic            ready_i,
  input  logic            flush_i,
  output logic            flush_done_o
);

  localparam int unsigned Width = InW + OutW;
  localparam int unsigned CntW  = $clog2(Width + 1);
  localparam int unsigned IdxW  = (InW > 1) ? $clog2(InW) : 1;
  localparam logic [CntW-1:0] OutWC  = CntW'(OutW);
  localparam logic [CntW-1:0] WidthC = CntW'(Width);

  typedef enum logic {StIdle, StDrain} fst_e;

  fst_e             fst_q, fst_d;
  logic [Width-1:0] sdata_q, sdata_d, smask_q, smask_d;
  logic [CntW-1:0]  cnt_q, cnt_d, base;
  logic [IdxW-1:0]  lod;
  logic [CntW-1:0]  n_in;
  logic [InW-1:0]   data_aligned, mask_aligned;
  logic             int_valid, ack_in, ack_out, drain_empty, flush_done;

  // Locate the lowest enabled input bit and count the enabled bits
  always_comb begin
    lod  = '0;
    n_in = '0;
    for (int i = int'(InW) - 1; i >= 0; i--) begin
      if (mask_i[i]) lod = IdxW'(i);
    end
    for (int i = 0; i < int'(InW); i++) begin
      n_in = n_in + CntW'(mask_i[i]);
    end
  end

  assign data_aligned = (data_i & mask_i) >> lod;
  assign mask_aligned = mask_i >> lod;

  assign int_valid = (cnt_q >= OutWC) || ((fst_q == StDrain) && (cnt_q != '0));
  assign ready_o   = (cnt_q <= OutWC) && (fst_q == StIdle);
  assign ack_in    = valid_i && ready_o;

`ifdef PRIM_UNPACKER_OUT_REG_EN
  logic            ovalid_q, ovalid_d;
  logic [OutW-1:0] odata_q, odata_d, omask_q, omask_d;

  assign ack_out     = int_valid && (!ovalid_q || ready_i);
  assign drain_empty = !ovalid_q;

  // Output stage refills from storage whenever it is empty or being consumed
  always_comb begin
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    omask_d  = omask_q;
    if (ack_out) begin
      ovalid_d = 1'b1;
      odata_d  = sdata_q[OutW-1:0];
      omask_d  = smask_q[OutW-1:0];
    end else if (ready_i) begin
      ovalid_d = 1'b0;
      odata_d  = '0;
      omask_d  = '0;
    end
  end

  // Output register state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      omask_q  <= '0;
    end else begin
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      omask_q  <= omask_d;
    end
  end

  assign valid_o = ovalid_q;
  assign data_o  = odata_q;
  assign mask_o  = omask_q;
`else
  assign ack_out     = int_valid && ready_i;
  assign drain_empty = 1'b1;
  assign valid_o     = int_valid;
  assign data_o      = sdata_q[OutW-1:0];
  assign mask_o      = smask_q[OutW-1:0];
`endif

  // Shift out consumed chunks, append new bits at the post-shift fill level, run the flush FSM
  always_comb begin
    fst_d      = fst_q;
    flush_done = 1'b0;
    base       = cnt_q;
    sdata_d    = sdata_q;
    smask_d    = smask_q;
    if (ack_out) begin
      base    = (cnt_q > OutWC) ? (cnt_q - OutWC) : '0;
      sdata_d = sdata_q >> OutW;
      smask_d = smask_q >> OutW;
    end
    cnt_d = base;
    if (ack_in) begin
      sdata_d = sdata_d | (Width'(data_aligned) << base);
      smask_d = smask_d | (Width'(mask_aligned) << base);
      cnt_d   = base + n_in;
    end
    case (fst_q)
      StIdle: begin
        if (flush_i) fst_d = StDrain;
      end
      StDrain: begin
        if ((cnt_q == '0) && drain_empty) begin
          flush_done = 1'b1;
          fst_d      = StIdle;
          sdata_d    = '0;
          smask_d    = '0;
          cnt_d      = '0;
        end
      end
      default: fst_d = StIdle;
    endcase
  end

  // Storage, fill counter and flush state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fst_q   <= StIdle;
      sdata_q <= '0;
      smask_q <= '0;
      cnt_q   <= '0;
    end else begin
      fst_q   <= fst_d;
      sdata_q <= sdata_d;
      smask_q <= smask_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flush_done_o = flush_done;

  logic mask_contig;
  assign mask_contig = ((mask_aligned & (mask_aligned + InW'(1))) == '0);

  a_mask_contig: assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_i |-> mask_contig);
  a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= WidthC);
  a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> (valid_o && $stable(data_o) && $stable(mask_o)));
  a_no_flush_with_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(flush_i && valid_i));
  a_no_valid_in_drain: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fst_q == StDrain) |-> !valid_i);
  a_flush_enters_drain: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (flush_i && (fst_q == StIdle)) |=> (fst_q == StDrain));
  a_drain_completes: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((fst_q == StDrain) && (cnt_q == '0) && drain_empty) |-> flush_done_o);
  a_byte_masks: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (HintByteData && valid_i) |-> (((int'(lod) % 8) == 0) && ((int'(n_in) % 8) == 0)));

endmodule
